// File: rtl/aes_apb_pkg.sv
// rtl/aes_apb_pkg.sv - register map and helpers shared by the AES APB slave and its feeder
package aes_apb_pkg;

  // Register offsets inside the AES slave window
  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_KEY    = 8'h04;
  localparam logic [7:0] OFS_PT     = 8'h14;
  localparam logic [7:0] OFS_IV     = 8'h24;
  localparam logic [7:0] OFS_CT     = 8'h34;
  localparam logic [7:0] OFS_STATUS = 8'h44;

  // CTRL bit positions
  localparam int CTRL_SOFT_RST     = 0;
  localparam int CTRL_INPUTS_VALID = 1;
  localparam int CTRL_ENCDEC       = 2;
  localparam int CTRL_MODE_LSB     = 3;

  // Mode codes; other codes are handed to the slave untouched
  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;

  // STATUS bit that flags a finished block
  localparam int STATUS_READY = 0;

  // Word 0 of a 128-bit register group carries the most significant bits
  function automatic logic [31:0] blk_word(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    return blk[127:96];
      2'd1:    return blk[95:64];
      2'd2:    return blk[63:32];
      default: return blk[31:0];
    endcase
  endfunction

  // Byte offset of word idx inside a four-word register group
  function automatic logic [7:0] word_ofs(input logic [7:0] base, input logic [1:0] idx);
    return base + {4'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// rtl/apb_master_xfer.sv - single APB transfer engine: SETUP, ACCESS, GAP
module apb_master_xfer #(
  parameter int vpindex  = 0,
  parameter int vnapbslv = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                write,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                done,
  output logic [31:0]         rdata,
  output logic [vnapbslv-1:0] psel,
  output logic                penable,
  output logic                pwrite,
  output logic [31:0]         paddr,
  output logic [31:0]         pwdata,
  input  logic [31:0]         prdata
);

  localparam logic [1:0] X_IDLE   = 2'd0;
  localparam logic [1:0] X_SETUP  = 2'd1;
  localparam logic [1:0] X_ACCESS = 2'd2;
  localparam logic [1:0] X_GAP    = 2'd3;

  localparam logic [vnapbslv-1:0] SEL_ONEHOT = vnapbslv'(1) << vpindex;

  logic [1:0]  st;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        active;

  // Step the three-cycle transfer; a request seen in GAP starts the next one with no idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= X_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      case (st)
        X_IDLE, X_GAP: begin
          if (req) begin
            st      <= X_SETUP;
            write_q <= write;
            addr_q  <= addr;
            wdata_q <= wdata;
          end else begin
            st <= X_IDLE;
          end
        end
        X_SETUP: st <= X_ACCESS;
        default: begin
          st <= X_GAP;
          if (!write_q) rdata <= prdata;
        end
      endcase
    end
  end

  // APB pins are forced to zero outside SETUP/ACCESS so the GAP cycle is fully quiet
  always_comb begin
    active  = (st == X_SETUP) || (st == X_ACCESS);
    psel    = active ? SEL_ONEHOT : '0;
    penable = (st == X_ACCESS);
    pwrite  = active && write_q;
    paddr   = active ? addr_q : '0;
    pwdata  = active ? wdata_q : '0;
    done    = (st == X_GAP);
  end

endmodule

// File: rtl/vlog_aes_apb_feeder.sv
// rtl/vlog_aes_apb_feeder.sv - APB master that configures the AES slave and streams blocks through it
module vlog_aes_apb_feeder
  import aes_apb_pkg::*;
#(
  parameter int          vpindex  = 0,
  parameter int          vnapbslv = 8,
  parameter logic [31:0] APB_BASE = 32'h80000800,
  parameter int          POLL_MAX = 1024
) (
  input  logic                vclk,
  input  logic                vrst,
  input  logic                cfg_load,
  input  logic [127:0]        cfg_key,
  input  logic [127:0]        cfg_iv,
  input  logic                cfg_encdec,
  input  logic [1:0]          cfg_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                busy,
  output logic                err,
  output logic [vnapbslv-1:0] vpsel,
  output logic                vpenable,
  output logic                vpwrite,
  output logic [31:0]         vpaddr,
  output logic [31:0]         vpwdata,
  input  logic [31:0]         vprdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_GO   = 3'd3;
  localparam logic [2:0] S_POLL = 3'd4;
  localparam logic [2:0] S_READ = 3'd5;
  localparam logic [2:0] S_OUT  = 3'd6;

  localparam int             PCW       = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  logic [2:0]     state, state_n;
  logic [3:0]     word_cnt, word_n;
  logic [PCW-1:0] poll_cnt;
  logic           cfg_done;
  logic [127:0]   key_q, iv_q, blk_q;
  logic           encdec_q;
  logic [1:0]     mode_q;

  logic           cfg_accept, blk_accept;
  logic           req, req_write;
  logic [7:0]     req_ofs;
  logic [31:0]    req_addr, req_wdata;
  logic [127:0]   pt_src;
  logic [1:0]     key_idx, iv_idx;
  logic           xfer_done;
  logic [31:0]    xfer_rdata;
  logic           status_ready;

  // Handshake and status outputs derived from the FSM state
  always_comb begin
    cfg_accept   = (state == S_IDLE) && cfg_load;
    in_ready     = (state == S_IDLE) && cfg_done && !cfg_load;
    blk_accept   = in_ready && in_valid;
    out_valid    = (state == S_OUT);
    busy         = (state != S_IDLE);
    status_ready = xfer_rdata[STATUS_READY];
  end

  // Next-state logic; req is raised on the cycle that decides the next transfer so transfers abut
  always_comb begin
    state_n = state;
    word_n  = word_cnt;
    req     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_accept) begin
          state_n = S_CFG;
          word_n  = 4'd0;
          req     = 1'b1;
        end else if (blk_accept) begin
          state_n = S_LOAD;
          word_n  = 4'd0;
          req     = 1'b1;
        end
      end
      S_CFG: begin
        if (xfer_done) begin
          if (word_cnt == 4'd9) begin
            state_n = S_IDLE;
            word_n  = 4'd0;
          end else begin
            word_n = word_cnt + 4'd1;
            req    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (xfer_done) begin
          req = 1'b1;
          if (word_cnt == 4'd3) begin
            state_n = S_GO;
            word_n  = 4'd0;
          end else begin
            word_n = word_cnt + 4'd1;
          end
        end
      end
      S_GO: begin
        if (xfer_done) begin
          state_n = S_POLL;
          req     = 1'b1;
        end
      end
      S_POLL: begin
        if (xfer_done) begin
          if (status_ready) begin
            state_n = S_READ;
            word_n  = 4'd0;
            req     = 1'b1;
          end else if (poll_cnt == POLL_LAST) begin
            state_n = S_IDLE;
          end else begin
            req = 1'b1;
          end
        end
      end
      S_READ: begin
        if (xfer_done) begin
          if (word_cnt == 4'd3) begin
            state_n = S_OUT;
            word_n  = 4'd0;
          end else begin
            word_n = word_cnt + 4'd1;
            req    = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Address and data for the transfer about to start, chosen from the upcoming state and word
  always_comb begin
    req_write = 1'b1;
    req_ofs   = OFS_CTRL;
    req_wdata = '0;
    key_idx   = 2'(word_n - 4'd2);
    iv_idx    = 2'(word_n - 4'd6);
    // The first PT word goes out on the accept cycle, before blk_q holds the block
    pt_src    = (state == S_IDLE) ? in_block : blk_q;
    case (state_n)
      S_CFG: begin
        if (word_n == 4'd0) begin
          req_wdata = 32'd1 << CTRL_SOFT_RST;
        end else if (word_n == 4'd1) begin
          req_wdata = '0;
        end else if (word_n < 4'd6) begin
          req_ofs   = word_ofs(OFS_KEY, key_idx);
          req_wdata = blk_word(key_q, key_idx);
        end else begin
          req_ofs   = word_ofs(OFS_IV, iv_idx);
          req_wdata = blk_word(iv_q, iv_idx);
        end
      end
      S_LOAD: begin
        req_ofs   = word_ofs(OFS_PT, word_n[1:0]);
        req_wdata = blk_word(pt_src, word_n[1:0]);
      end
      S_GO: begin
        req_wdata = (32'(mode_q) << CTRL_MODE_LSB) | (32'(encdec_q) << CTRL_ENCDEC)
                  | (32'd1 << CTRL_INPUTS_VALID);
      end
      S_POLL: begin
        req_write = 1'b0;
        req_ofs   = OFS_STATUS;
      end
      S_READ: begin
        req_write = 1'b0;
        req_ofs   = word_ofs(OFS_CT, word_n[1:0]);
      end
      default: req_write = 1'b0;
    endcase
    req_addr = APB_BASE + {24'd0, req_ofs};
  end

  // FSM registers, configuration capture, poll accounting and result assembly
  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      poll_cnt  <= '0;
      cfg_done  <= 1'b0;
      err       <= 1'b0;
      key_q     <= '0;
      iv_q      <= '0;
      blk_q     <= '0;
      encdec_q  <= 1'b0;
      mode_q    <= '0;
      out_block <= '0;
    end else begin
      state    <= state_n;
      word_cnt <= word_n;
      if (cfg_accept) begin
        key_q    <= cfg_key;
        iv_q     <= cfg_iv;
        encdec_q <= cfg_encdec;
        mode_q   <= cfg_mode;
        err      <= 1'b0;
      end
      if (blk_accept) blk_q <= in_block;
      if (state == S_CFG && xfer_done && word_cnt == 4'd9) cfg_done <= 1'b1;
      if (state != S_POLL && state_n == S_POLL) begin
        poll_cnt <= '0;
      end else if (state == S_POLL && xfer_done && !status_ready) begin
        if (poll_cnt == POLL_LAST) begin
          err      <= 1'b1;
          cfg_done <= 1'b0;
        end else begin
          poll_cnt <= poll_cnt + 1'b1;
        end
      end
      if (state == S_READ && xfer_done) begin
        case (word_cnt[1:0])
          2'd0:    out_block[127:96] <= xfer_rdata;
          2'd1:    out_block[95:64]  <= xfer_rdata;
          2'd2:    out_block[63:32]  <= xfer_rdata;
          default: out_block[31:0]   <= xfer_rdata;
        endcase
      end
    end
  end

  apb_master_xfer #(
    .vpindex (vpindex),
    .vnapbslv(vnapbslv)
  ) u_xfer (
    .clk    (vclk),
    .rst_n  (vrst),
    .req    (req),
    .write  (req_write),
    .addr   (req_addr),
    .wdata  (req_wdata),
    .done   (xfer_done),
    .rdata  (xfer_rdata),
    .psel   (vpsel),
    .penable(vpenable),
    .pwrite (vpwrite),
    .paddr  (vpaddr),
    .pwdata (vpwdata),
    .prdata (vprdata)
  );

endmodule

// File: tb/tb_vlog_aes_apb_feeder.sv
// tb/tb_vlog_aes_apb_feeder.sv - scoreboard bench for the AES APB feeder with a table-driven slave stub
module tb_vlog_aes_apb_feeder;

  localparam logic [31:0]  BASE = 32'h80000800;
  localparam int           IDX  = 2;
  localparam logic [7:0]   SEL  = 8'b0000_0100;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P3  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C3  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] BAD = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         vclk = 1'b0;
  logic         vrst = 1'b0;
  logic         cfg_load = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_encdec = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_block;
  logic         busy;
  logic         err;
  logic [7:0]   vpsel;
  logic         vpenable;
  logic         vpwrite;
  logic [31:0]  vpaddr;
  logic [31:0]  vpwdata;
  logic [31:0]  vprdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] out_q[$];
  logic [64:0]  apb_q[$];
  logic         trace_on = 1'b0;
  int           status_reads = 0;
  logic [31:0]  last_go = '0;

  // Slave stub state
  logic [127:0] s_key = '0, s_pt = '0, s_iv = '0, s_ct = '0;
  int           s_rsg = 0;
  int           s_idx = 0;
  logic         stuck = 1'b0;

  always #5 vclk = ~vclk;
  always @(posedge vclk) cyc <= cyc + 1;

  vlog_aes_apb_feeder #(
    .vpindex (IDX),
    .vnapbslv(8),
    .APB_BASE(BASE),
    .POLL_MAX(8)
  ) dut (
    .vclk      (vclk),
    .vrst      (vrst),
    .cfg_load  (cfg_load),
    .cfg_key   (cfg_key),
    .cfg_iv    (cfg_iv),
    .cfg_encdec(cfg_encdec),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy),
    .err       (err),
    .vpsel     (vpsel),
    .vpenable  (vpenable),
    .vpwrite   (vpwrite),
    .vpaddr    (vpaddr),
    .vpwdata   (vpwdata),
    .vprdata   (vprdata)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [255:0] outs_vec();
    return {50'd0, vpsel, vpenable, vpwrite, vpaddr, vpwdata, out_valid, out_block, busy, err, in_ready};
  endfunction

  // Known-answer table: returns the published ciphertext only when the programmed state matches
  function automatic logic [127:0] lookup(input logic [127:0] k, input logic [127:0] iv,
                                          input logic [127:0] pt, input logic [31:0] ctrl,
                                          input int idx);
    if (ctrl[31:5] != 0 || ctrl[0] || !ctrl[2]) return BAD;
    if (k == K1 && ctrl[4:3] == 2'b00 && pt == P1) return C1;
    if (k == K2 && iv == IV2 && ctrl[4:3] == 2'b01 && pt == P2 && idx == 0) return C2;
    if (k == K2 && iv == IV2 && ctrl[4:3] == 2'b01 && pt == P3 && idx == 1) return C3;
    return BAD;
  endfunction

  // Slave stub register writes; ready appears on the second STATUS read after GO
  always @(posedge vclk) begin
    if (vrst && vpsel[IDX] && vpenable && vpwrite) begin
      case (vpaddr - BASE)
        32'h00: if (vpwdata[1]) begin
          s_ct  <= lookup(s_key, s_iv, s_pt, vpwdata, s_idx);
          s_idx <= s_idx + 1;
          s_rsg <= 0;
        end
        32'h04: s_key[127:96] <= vpwdata;
        32'h08: s_key[95:64]  <= vpwdata;
        32'h0c: s_key[63:32]  <= vpwdata;
        32'h10: s_key[31:0]   <= vpwdata;
        32'h14: s_pt[127:96]  <= vpwdata;
        32'h18: s_pt[95:64]   <= vpwdata;
        32'h1c: s_pt[63:32]   <= vpwdata;
        32'h20: s_pt[31:0]    <= vpwdata;
        32'h24: begin s_iv[127:96] <= vpwdata; s_idx <= 0; end
        32'h28: begin s_iv[95:64]  <= vpwdata; s_idx <= 0; end
        32'h2c: begin s_iv[63:32]  <= vpwdata; s_idx <= 0; end
        32'h30: begin s_iv[31:0]   <= vpwdata; s_idx <= 0; end
        default: ;
      endcase
    end else if (vrst && vpsel[IDX] && vpenable && vpaddr == BASE + 32'h44) begin
      s_rsg <= s_rsg + 1;
    end
  end

  always_comb begin
    vprdata = 32'h0;
    if (vpsel[IDX] && vpenable && !vpwrite) begin
      case (vpaddr - BASE)
        32'h44:  vprdata = {31'd0, (!stuck && s_rsg != 0)};
        32'h34:  vprdata = s_ct[127:96];
        32'h38:  vprdata = s_ct[95:64];
        32'h3c:  vprdata = s_ct[63:32];
        32'h40:  vprdata = s_ct[31:0];
        default: vprdata = 32'h0;
      endcase
    end
  end

  // APB monitor: transfer shape, quiet GAP, select line, config trace scoreboard
  initial begin
    logic        prev_setup;
    logic        prev_access;
    logic [64:0] setup_rec;
    logic [64:0] exp_rec;
    prev_setup  = 1'b0;
    prev_access = 1'b0;
    setup_rec   = '0;
    forever begin
      @(negedge vclk);
      if (!vrst) begin
        prev_setup  = 1'b0;
        prev_access = 1'b0;
      end else begin
        if (prev_access)
          check("apb_gap_quiet", 256'({vpsel, vpenable, vpwrite, vpaddr, vpwdata}), 256'(0));
        if (vpsel != 0 && !vpenable) begin
          check("apb_psel", 256'(vpsel), 256'(SEL));
          setup_rec = {vpwrite, vpaddr, vpwdata};
        end
        if (vpenable) begin
          check("apb_setup_then_access", 256'({prev_setup, vpsel, vpwrite, vpaddr, vpwdata}),
                256'({1'b1, SEL, setup_rec}));
          if (!vpwrite && vpaddr == BASE + 32'h44) status_reads++;
          if (vpwrite && vpaddr == BASE && vpwdata[1]) last_go = vpwdata;
          if (trace_on) begin
            if (apb_q.size() == 0) begin
              check("apb_trace_extra", 256'({vpwrite, vpaddr, vpwdata}), 256'(0));
            end else begin
              exp_rec = apb_q.pop_front();
              check("apb_trace", 256'({vpwrite, vpaddr, vpwdata}), 256'(exp_rec));
            end
          end
        end
        prev_setup  = (vpsel != 0) && !vpenable;
        prev_access = vpenable;
      end
    end
  end

  // Output monitor: scoreboard pops, accept-to-valid latency, single-cycle OUT under ready
  initial begin
    logic         prev_hs;
    logic         prev_ov;
    int           accept_edge;
    logic [127:0] exp_blk;
    prev_hs     = 1'b0;
    prev_ov     = 1'b0;
    accept_edge = -1;
    forever begin
      @(negedge vclk);
      if (!vrst) begin
        prev_hs     = 1'b0;
        prev_ov     = 1'b0;
        accept_edge = -1;
      end else begin
        if (prev_hs) check("out_one_cycle", 256'(out_valid), 256'(0));
        if (out_valid && !prev_ov && accept_edge >= 0)
          check("latency", 256'(cyc - accept_edge), 256'(33));
        if (out_valid && out_ready) begin
          if (out_q.size() == 0) begin
            check("out_unexpected", 256'(out_block), 256'(0));
          end else begin
            exp_blk = out_q.pop_front();
            check("out_block", 256'(out_block), 256'(exp_blk));
          end
        end
        prev_hs = out_valid && out_ready;
        prev_ov = out_valid;
        if (in_valid && in_ready) accept_edge = cyc + 1;
      end
    end
  end

  task automatic wait_idle(input int bound, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge vclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input logic encdec,
                        input logic [1:0] mode, input logic trace);
    wait_idle(400, "cfg_wait_idle");
    if (trace) begin
      apb_q.push_back({1'b1, BASE, 32'h1});
      apb_q.push_back({1'b1, BASE, 32'h0});
      apb_q.push_back({1'b1, BASE + 32'h04, k[127:96]});
      apb_q.push_back({1'b1, BASE + 32'h08, k[95:64]});
      apb_q.push_back({1'b1, BASE + 32'h0c, k[63:32]});
      apb_q.push_back({1'b1, BASE + 32'h10, k[31:0]});
      apb_q.push_back({1'b1, BASE + 32'h24, iv[127:96]});
      apb_q.push_back({1'b1, BASE + 32'h28, iv[95:64]});
      apb_q.push_back({1'b1, BASE + 32'h2c, iv[63:32]});
      apb_q.push_back({1'b1, BASE + 32'h30, iv[31:0]});
      trace_on = 1'b1;
    end
    @(posedge vclk);
    #1;
    cfg_key    = k;
    cfg_iv     = iv;
    cfg_encdec = encdec;
    cfg_mode   = mode;
    cfg_load   = 1'b1;
    @(posedge vclk);
    #1;
    cfg_load = 1'b0;
    wait_idle(100, "cfg_done_wait");
    if (trace) begin
      check("cfg_trace_consumed", 256'(apb_q.size()), 256'(0));
      trace_on = 1'b0;
    end
  endtask

  task automatic send_block(input logic [127:0] pt, input logic expect_out, input logic [127:0] exp);
    logic ok;
    @(posedge vclk);
    #1;
    in_block = pt;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge vclk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("in_ready_wait");
    if (ok && expect_out) out_q.push_back(exp);
    @(posedge vclk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int  bp_bad;
    logic ok;

    // Reset state
    repeat (3) @(negedge vclk);
    check("reset_outputs", outs_vec(), 256'(0));
    @(posedge vclk);
    #1;
    vrst     = 1'b1;
    in_valid = 1'b1;
    in_block = P1;
    repeat (5) begin
      @(negedge vclk);
      check("in_ready_before_cfg", 256'({in_ready, busy}), 256'(0));
    end
    @(posedge vclk);
    #1;
    in_valid = 1'b0;

    // ECB encrypt, FIPS-197 C.1
    do_cfg(K1, 128'd0, 1'b1, 2'b00, 1'b1);
    check("cfg_err_clear", 256'({err, in_ready}), 256'(2'b01));
    send_block(P1, 1'b1, C1);
    wait_idle(200, "ecb_done");

    // CBC encrypt, SP800-38A F.2.1, two chained blocks; the second held by backpressure
    do_cfg(K2, IV2, 1'b1, 2'b01, 1'b1);
    send_block(P2, 1'b1, C2);
    wait_idle(200, "cbc1_done");
    @(posedge vclk);
    #1;
    out_ready = 1'b0;
    send_block(P3, 1'b1, C3);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge vclk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("out_valid_wait");
    bp_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vclk);
      if (!(out_valid && out_block == C3 && !in_ready && vpsel == 0 && !vpenable)) bp_bad++;
    end
    check("backpressure_hold", 256'(bp_bad), 256'(0));
    @(posedge vclk);
    #1;
    out_ready = 1'b1;
    wait_idle(50, "bp_release");

    // Reset in the middle of an ACCESS cycle
    @(posedge vclk);
    #1;
    cfg_load = 1'b1;
    @(posedge vclk);
    #1;
    cfg_load = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vclk);
      if (vpenable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("access_wait");
    #2;
    vrst = 1'b0;
    #1;
    check("reset_mid_access", outs_vec(), 256'(0));
    @(negedge vclk);
    vrst = 1'b1;
    @(posedge vclk);
    #1;
    in_valid = 1'b1;
    @(negedge vclk);
    check("in_ready_after_reset", 256'({in_ready, busy}), 256'(0));
    @(posedge vclk);
    #1;
    in_valid = 1'b0;

    // Poll timeout with a slave that never reports ready; mode 11 decrypt is passed through
    do_cfg(K2, IV2, 1'b0, 2'b11, 1'b0);
    stuck        = 1'b1;
    status_reads = 0;
    send_block(P2, 1'b0, 128'd0);
    wait_idle(200, "timeout_idle");
    check("timeout_status_reads", 256'(status_reads), 256'(8));
    check("timeout_err_ready", 256'({err, in_ready}), 256'(2'b10));
    check("go_ctrl_passthrough", 256'(last_go), 256'(32'h1a));
    stuck = 1'b0;
    do_cfg(K1, 128'd0, 1'b1, 2'b00, 1'b0);
    check("err_cleared_by_cfg", 256'({err, in_ready}), 256'(2'b01));
    check("scoreboard_drained", 256'(out_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
